// File: rtl/ecliptic_minmax_reduce_if.sv
// Handshake bundle for the streaming FP min/max reduction unit.
// The master side feeds operand beats and consumes the result;
// the slave side is the reduction unit itself.
interface ecliptic_minmax_reduce_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int CNT_W  = 8
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic             req;
    logic             ready;
    logic [W-1:0]     src;
    logic             op;
    logic             last;
    logic             ack;
    logic             res_ready;
    logic [W-1:0]     res;
    logic             invalid;
    logic [CNT_W-1:0] count;

    modport master (
        output req, src, op, last, res_ready,
        input  ready, ack, res, invalid, count
    );

    modport slave (
        input  req, src, op, last, res_ready,
        output ready, ack, res, invalid, count
    );
endinterface

// File: rtl/ecliptic_minmax_reduce.sv
// Streaming floating-point min/max reduction.
// Folds a burst of operands with RISC-V FMIN/FMAX semantics (NaN operands
// are skipped, -0 orders below +0, sNaN raises invalid) and hands back one
// result. NaN payloads are never propagated: an all-NaN burst yields the
// canonical quiet NaN.
module ecliptic_minmax_reduce #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    ecliptic_minmax_reduce_if.slave  bus
);
    localparam int W = 1 + EXP_W + FRAC_W;
    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             ready_s;
    logic             beat_s;
    logic [W-1:0]     next_acc_s;
    logic [W-1:0]     acc_r;
    logic             op_r;
    logic [CNT_W-1:0] count_r;
    logic             invalid_r;
    logic [W-1:0]     res_r;
    logic             ack_r;

    function automatic logic is_nan(input logic [W-1:0] v);
        return (&v[W-2:FRAC_W]) && (|v[FRAC_W-1:0]);
    endfunction

    function automatic logic is_snan(input logic [W-1:0] v);
        return is_nan(v) && !v[FRAC_W-1];
    endfunction

    // Strict IEEE "less than" on non-NaN operands, with -0 below +0.
    function automatic logic fp_lt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic lt;
        if (a[W-1] != b[W-1]) begin
            lt = a[W-1];
        end else if (a[W-1] == 1'b0) begin
            lt = (a[W-2:0] < b[W-2:0]);
        end else begin
            lt = (a[W-2:0] > b[W-2:0]);
        end
        return lt;
    endfunction

    // Pairwise fold: NaNs are dropped in favour of the other operand.
    function automatic logic [W-1:0] fold(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic is_max);
        logic [W-1:0] r;
        if (is_nan(a) && is_nan(b)) begin
            r = CANON_NAN;
        end else if (is_nan(a)) begin
            r = b;
        end else if (is_nan(b)) begin
            r = a;
        end else if (is_max) begin
            r = fp_lt(a, b) ? b : a;
        end else begin
            r = fp_lt(a, b) ? a : b;
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, ready, beat acceptance and the folded accumulator value.
    always_comb begin
        next_state_s = state_r;
        ready_s      = 1'b0;
        beat_s       = 1'b0;
        next_acc_s   = acc_r;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (bus.req) begin
                    beat_s       = 1'b1;
                    next_acc_s   = bus.src;
                    next_state_s = bus.last ? DONE : ACCUM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCUM: begin
                ready_s = 1'b1;
                if (bus.req) begin
                    beat_s       = 1'b1;
                    next_acc_s   = fold(acc_r, bus.src, op_r);
                    next_state_s = bus.last ? DONE : ACCUM;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Accumulator, op latch, counters, flags and the registered result.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            acc_r     <= {W{1'b0}};
            op_r      <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            invalid_r <= 1'b0;
            res_r     <= {W{1'b0}};
            ack_r     <= 1'b0;
        end else begin
            if (beat_s) begin
                acc_r <= next_acc_s;
                if (state_r == IDLE) begin
                    op_r      <= bus.op;
                    count_r   <= CNT_ONE;
                    invalid_r <= is_snan(bus.src);
                end else begin
                    count_r   <= (&count_r) ? count_r : count_r + CNT_ONE;
                    invalid_r <= invalid_r | is_snan(bus.src);
                end
                if (next_state_s == DONE) begin
                    res_r <= is_nan(next_acc_s) ? CANON_NAN : next_acc_s;
                end
            end
            ack_r <= (next_state_s == DONE);
        end
    end

    assign bus.ready   = ready_s;
    assign bus.ack     = ack_r;
    assign bus.res     = res_r;
    assign bus.invalid = invalid_r;
    assign bus.count   = count_r;
endmodule

// File: tb/tb_ecliptic_minmax_reduce.sv
// Directed bench for ecliptic_minmax_reduce: FP32 build plus a CNT_W=2
// build for counter saturation. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_ecliptic_minmax_reduce;
    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    ecliptic_minmax_reduce_if #(.EXP_W(8), .FRAC_W(23), .CNT_W(8)) u_if ();
    ecliptic_minmax_reduce_if #(.EXP_W(8), .FRAC_W(23), .CNT_W(2)) u_if2 ();

    ecliptic_minmax_reduce #(.EXP_W(8), .FRAC_W(23), .CNT_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (u_if.slave)
    );

    ecliptic_minmax_reduce #(.EXP_W(8), .FRAC_W(23), .CNT_W(2)) dut2 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (u_if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat for exactly one rising edge; called at a falling edge.
    task automatic beat(input logic [31:0] s, input logic o, input logic l);
        u_if.req  = 1'b1;
        u_if.src  = s;
        u_if.op   = o;
        u_if.last = l;
        @(negedge clk);
        u_if.req  = 1'b0;
        u_if.last = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] r, input logic inv,
                                input logic [31:0] cnt);
        check({tag, "_ack"}, {31'd0, u_if.ack}, 32'd1);
        check({tag, "_res"}, u_if.res, r);
        check({tag, "_inv"}, {31'd0, u_if.invalid}, {31'd0, inv});
        check({tag, "_cnt"}, {24'd0, u_if.count}, cnt);
        check({tag, "_rdy"}, {31'd0, u_if.ready}, 32'd0);
    endtask

    // Release the result and confirm the unit is back in IDLE.
    task automatic take(input string tag);
        u_if.res_ready = 1'b1;
        @(negedge clk);
        u_if.res_ready = 1'b0;
        check({tag, "_ackdrop"}, {31'd0, u_if.ack}, 32'd0);
        check({tag, "_rdyback"}, {31'd0, u_if.ready}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nrst = 1'b1;
        u_if.req = 1'b0;  u_if.src = 32'd0;  u_if.op = 1'b0;  u_if.last = 1'b0;  u_if.res_ready = 1'b0;
        u_if2.req = 1'b0; u_if2.src = 32'd0; u_if2.op = 1'b0; u_if2.last = 1'b0; u_if2.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", {31'd0, u_if.ready}, 32'd1);
        check("rst_ack", {31'd0, u_if.ack}, 32'd0);
        check("rst_res", u_if.res, 32'h0000_0000);
        check("rst_inv", {31'd0, u_if.invalid}, 32'd0);
        check("rst_cnt", {24'd0, u_if.count}, 32'd0);

        // Max of 1.0, -4.29e9, 2.0
        beat(32'h3f80_0000, 1'b1, 1'b0);
        check("max3_noack1", {31'd0, u_if.ack}, 32'd0);
        beat(32'hcf80_0000, 1'b0, 1'b0);
        check("max3_noack2", {31'd0, u_if.ack}, 32'd0);
        beat(32'h4000_0000, 1'b0, 1'b1);
        check_result("max3", 32'h4000_0000, 1'b0, 32'd3);
        take("max3");

        // sNaN then 1.0, min
        beat(32'h7f80_0001, 1'b0, 1'b0);
        beat(32'h3f80_0000, 1'b1, 1'b1);
        check_result("snanmin", 32'h3f80_0000, 1'b1, 32'd2);
        take("snanmin");

        // Single quiet NaN beat: canonical NaN, not invalid
        beat(32'h7fc1_2345, 1'b0, 1'b1);
        check_result("qnan1", 32'h7fc0_0000, 1'b0, 32'd1);
        take("qnan1");

        // Single signalling NaN beat: canonical NaN, invalid
        beat(32'h7f80_0001, 1'b0, 1'b1);
        check_result("snan1", 32'h7fc0_0000, 1'b1, 32'd1);
        take("snan1");
        check("snan1_inv_kept", {31'd0, u_if.invalid}, 32'd1);

        // Signed zeros
        beat(32'h0000_0000, 1'b0, 1'b0);
        beat(32'h8000_0000, 1'b0, 1'b1);
        check_result("zmin", 32'h8000_0000, 1'b0, 32'd2);
        take("zmin");
        beat(32'h0000_0000, 1'b1, 1'b0);
        beat(32'h8000_0000, 1'b1, 1'b1);
        check_result("zmax", 32'h0000_0000, 1'b0, 32'd2);
        take("zmax");
        beat(32'h8000_0000, 1'b1, 1'b0);
        beat(32'h0000_0000, 1'b1, 1'b1);
        check_result("zmax_rev", 32'h0000_0000, 1'b0, 32'd2);
        take("zmax_rev");

        // Negative operands, max, then backpressure with ignored beats
        beat(32'hbf80_0000, 1'b1, 1'b0);
        beat(32'hc000_0000, 1'b0, 1'b1);
        check_result("neg", 32'hbf80_0000, 1'b0, 32'd2);
        for (int i = 0; i < 5; i++) begin
            u_if.req  = 1'b1;
            u_if.src  = 32'h1234_5678;
            u_if.op   = 1'b0;
            u_if.last = 1'b1;
            @(negedge clk);
            check_result("bp", 32'hbf80_0000, 1'b0, 32'd2);
        end
        u_if.req  = 1'b0;
        u_if.last = 1'b0;
        take("bp");
        check("bp_cnt_kept", {24'd0, u_if.count}, 32'd2);

        // Reset in the middle of an accumulation
        beat(32'h4000_0000, 1'b1, 1'b0);
        beat(32'h4040_0000, 1'b1, 1'b0);
        check("midrst_cnt_pre", {24'd0, u_if.count}, 32'd2);
        nrst = 1'b1;
        #1;
        check("midrst_ack", {31'd0, u_if.ack}, 32'd0);
        check("midrst_ready", {31'd0, u_if.ready}, 32'd1);
        check("midrst_cnt", {24'd0, u_if.count}, 32'd0);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        beat(32'h3f80_0000, 1'b0, 1'b1);
        check_result("postrst", 32'h3f80_0000, 1'b0, 32'd1);
        take("postrst");

        // CNT_W=2 build: five beats saturate the counter at 3
        for (int i = 0; i < 5; i++) begin
            u_if2.req  = 1'b1;
            u_if2.op   = 1'b1;
            u_if2.last = (i == 4);
            case (i)
                0: u_if2.src = 32'h3f80_0000;
                1: u_if2.src = 32'h4000_0000;
                2: u_if2.src = 32'h4040_0000;
                3: u_if2.src = 32'h4080_0000;
                default: u_if2.src = 32'h40a0_0000;
            endcase
            @(negedge clk);
        end
        u_if2.req  = 1'b0;
        u_if2.last = 1'b0;
        check("sat_ack", {31'd0, u_if2.ack}, 32'd1);
        check("sat_cnt", {30'd0, u_if2.count}, 32'd3);
        check("sat_res", u_if2.res, 32'h40a0_0000);
        u_if2.res_ready = 1'b1;
        @(negedge clk);
        u_if2.res_ready = 1'b0;
        check("sat_ackdrop", {31'd0, u_if2.ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
